// File: rtl/sipo_rx_pkg.sv
// sipo_rx_pkg: shared state encodings, frame bit levels and counter-width helper
package sipo_rx_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd2} state_t;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sipo_rx.sv
// sipo_rx: framed serial receiver assembling w-bit LSB-first words with load and frame-error strobes
module sipo_rx
  import sipo_rx_pkg::*;
#(
  parameter int w = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         sin,
  output logic [w-1:0] d,
  output logic         ld,
  output logic         ferr,
  output logic         busy
);
  localparam int cw = clog2(w);
  state_t state, state_n;
  logic [cw-1:0] cnt;
  logic [w-1:0] shreg;
  logic stop_tick;
  // next-state decode; the unused encoding falls back to IDLE
  always_comb begin
    stop_tick = tick && state == STOP;
    state_n = state;
    case (state)
      IDLE: state_n = (tick && sin == START_BIT) ? DATA : IDLE;
      DATA: state_n = (tick && cnt == cw'(w - 1)) ? STOP : DATA;
      STOP: state_n = tick ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  // state, datapath and registered outputs; strobes self-clear every edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      shreg <= '0;
      d <= '0;
      ld <= 1'b0;
      ferr <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      busy <= state_n != IDLE;
      ld <= stop_tick && sin == STOP_BIT;
      ferr <= stop_tick && sin != STOP_BIT;
      if (tick && state == IDLE) cnt <= '0;
      if (tick && state == DATA) begin
        shreg <= {sin, shreg[w-1:1]};
        cnt <= cnt + cw'(1);
      end
      if (stop_tick && sin == STOP_BIT) d <= shreg;
    end
  end
endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: randomized and directed frames checked each cycle against a bit-counting reference model
module tb_sipo_rx;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, sin = 1'b1;
  logic [W-1:0] d;
  logic ld, ferr, busy;
  int vecs = 0, errs = 0, cyc = 0, last_ld = 0, ld_gap = 0;
  int m_n;
  logic [W-1:0] m_word, m_d;
  logic m_ld, m_ferr;

  sipo_rx #(.w(W)) dut (.clk(clk), .rst(rst), .tick(tick), .sin(sin), .d(d), .ld(ld), .ferr(ferr), .busy(busy));

  always #5 clk = ~clk;

  // reference: m_n counts ticks taken inside a frame (0 = idle, w+1 = awaiting stop)
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n <= 0;
      m_word <= '0;
      m_d <= '0;
      m_ld <= 1'b0;
      m_ferr <= 1'b0;
    end else begin
      m_ld <= 1'b0;
      m_ferr <= 1'b0;
      if (tick) begin
        if (m_n == 0) begin
          if (!sin) begin
            m_n <= 1;
            m_word <= '0;
          end
        end else if (m_n <= W) begin
          m_word[m_n-1] <= sin;
          m_n <= m_n + 1;
        end else begin
          m_n <= 0;
          if (sin) begin
            m_d <= m_word;
            m_ld <= 1'b1;
          end else m_ferr <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic t, input logic s);
    tick = t;
    sin = s;
    @(posedge clk);
    #1;
    cyc++;
    chk("d", 32'(d), 32'(m_d));
    chk("ld", 32'(ld), 32'(m_ld));
    chk("ferr", 32'(ferr), 32'(m_ferr));
    chk("busy", 32'(busy), 32'(m_n != 0));
    if (ld) begin
      ld_gap = cyc - last_ld;
      last_ld = cyc;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] v, input logic sb, input int gap);
    logic [W+1:0] f;
    f = {sb, v, 1'b0};
    for (int i = 0; i < W + 2; i++) begin
      repeat (gap) step(1'b0, 1'($urandom_range(0, 1)));
      step(1'b1, f[i]);
    end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_d", 32'(d), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ld", 32'(ld), 32'h0);
    rst = 1'b0;
    send(8'hA5, 1'b1, 0);
    chk("a5_ld", 32'(ld), 32'h1);
    chk("a5_d", 32'(d), 32'hA5);
    send(8'h3C, 1'b0, 0);
    chk("err_ferr", 32'(ferr), 32'h1);
    chk("err_ld", 32'(ld), 32'h0);
    chk("err_d", 32'(d), 32'hA5);
    send(8'h3C, 1'b1, 3);
    chk("sparse_ld", 32'(ld), 32'h1);
    chk("sparse_d", 32'(d), 32'h3C);
    send(8'h01, 1'b1, 0);
    chk("b2b_d1", 32'(d), 32'h01);
    send(8'hFF, 1'b1, 0);
    chk("b2b_d2", 32'(d), 32'hFF);
    chk("b2b_gap", 32'(ld_gap), 32'd10);
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom_range(0, 1)));
    #2 rst = 1'b1;
    #1;
    chk("mid_d", 32'(d), 32'h0);
    chk("mid_busy", 32'(busy), 32'h0);
    chk("mid_ld", 32'(ld | ferr), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    send(8'h5A, 1'b1, 0);
    chk("post_d", 32'(d), 32'h5A);
    chk("post_ld", 32'(ld), 32'h1);
    repeat (20) step(1'b1, 1'b1);
    chk("idle_busy", 32'(busy), 32'h0);
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) step(1'($urandom_range(0, 1)), 1'b1);
      send(W'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2));
    end
    repeat (5) step(1'b0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
